// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt controller.
//   Register offsets on reg_adr[3:2] and the "no source" claim ID.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_ENABLE  = 2'd0;
    localparam logic [1:0] IRQ_MODE    = 2'd1;
    localparam logic [1:0] IRQ_PENDING = 2'd2;
    localparam logic [1:0] IRQ_CLAIM   = 2'd3;

    localparam int ID_NONE = 0;

endpackage

// File: rtl/irq_ctrl_sync.sv
// irq_sync: per-source synchronizer and rising-edge detector.
//   clk, rst_n : core clock, synchronous active-low reset
//   irq_in     : asynchronous source
//   lvl        : synchronized level (last sync flop)
//   rise       : 0->1 between last sync flop and the detect flop
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   det_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            det_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            det_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = sync_q[SYNC_STAGES-1] & ~det_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source machine-level interrupt controller.
//   clk, rst_n     : core clock, synchronous active-low reset
//   irq_in         : N_IRQ asynchronous sources, active high
//   csr_meie       : machine external interrupt enable
//   reg_we/reg_re  : register write / read strobes
//   reg_adr        : register select (ENABLE, MODE, PENDING, CLAIM)
//   reg_wdata      : write data
//   reg_rdata      : registered read data, holds until the next read
//   g_interrupt    : registered interrupt request to the pipeline
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(N_IRQ + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             csr_meie,
    input  logic             reg_we,
    input  logic             reg_re,
    input  logic [3:2]       reg_adr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             g_interrupt
);

    logic [N_IRQ-1:0] lvl, rise;
    logic [N_IRQ-1:0] enable_q, mode_q, pending_q, pend_d;
    logic [ID_W-1:0]  insvc_q;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_src
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .irq_in (irq_in[i]),
            .lvl    (lvl[i]),
            .rise   (rise[i])
        );
    end

    // Fixed priority: lowest index wins. cand_oh isolates the lowest set bit.
    logic [N_IRQ-1:0] act, cand_oh;
    logic [ID_W-1:0]  cand_id;
    logic             cand_hit;

    assign act      = pending_q & enable_q;
    assign cand_oh  = act & (~act + N_IRQ'(1));
    assign cand_hit = |act;

    always_comb begin
        cand_id = ID_W'(ID_NONE);
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (act[i]) cand_id = ID_W'(i + 1);
    end

    logic [N_IRQ-1:0] wbits;
    logic             idle, wr_en, wr_mode, wr_pend, wr_claim, rd_claim;
    logic             claim_go, complete_go;

    assign wbits    = reg_wdata[N_IRQ-1:0];
    assign idle     = (insvc_q == ID_W'(ID_NONE));
    assign wr_en    = reg_we && reg_adr == IRQ_ENABLE;
    assign wr_mode  = reg_we && reg_adr == IRQ_MODE;
    assign wr_pend  = reg_we && reg_adr == IRQ_PENDING;
    assign wr_claim = reg_we && reg_adr == IRQ_CLAIM;
    assign rd_claim = reg_re && reg_adr == IRQ_CLAIM;

    // A simultaneous read+write on CLAIM performs only the complete.
    assign claim_go    = rd_claim && !wr_claim && idle && cand_hit;
    assign complete_go = wr_claim && !idle && (reg_wdata[ID_W-1:0] == insvc_q);

    // Edge bits: clears from claim / W1C, then a new rise overrides (set wins).
    // Level bits track the synced level; a level->edge MODE write drops the
    // stale level state, keeping only a rise in that same cycle.
    logic [N_IRQ-1:0] edge_next, lvl_next, clr_mask, to_edge;

    assign clr_mask  = (claim_go ? cand_oh : '0) | (wr_pend ? wbits : '0);
    assign to_edge   = wr_mode ? wbits : '0;
    assign edge_next = (pending_q & ~clr_mask) | rise;
    assign lvl_next  = (lvl & ~to_edge) | (rise & to_edge);
    assign pend_d    = (mode_q & edge_next) | (~mode_q & lvl_next);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pending_q   <= '0;
            insvc_q     <= '0;
            reg_rdata   <= '0;
            g_interrupt <= 1'b0;
        end else begin
            pending_q   <= pend_d;
            g_interrupt <= csr_meie & idle & cand_hit;
            if (wr_en)   enable_q <= wbits;
            if (wr_mode) mode_q   <= wbits;
            if (complete_go)   insvc_q <= ID_W'(ID_NONE);
            else if (claim_go) insvc_q <= cand_id;
            // Reads use pre-write state, so a same-cycle write is not visible.
            if (reg_re) begin
                case (reg_adr)
                    IRQ_ENABLE:  reg_rdata <= 32'(enable_q);
                    IRQ_MODE:    reg_rdata <= 32'(mode_q);
                    IRQ_PENDING: reg_rdata <= 32'(pending_q);
                    default:     reg_rdata <= claim_go ? 32'(cand_id) : '0;
                endcase
            end
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        csr_meie = 1'b0;
    logic        reg_we = 1'b0;
    logic        reg_re = 1'b0;
    logic [3:2]  reg_adr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        g_interrupt;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .csr_meie    (csr_meie),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_adr     (reg_adr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .g_interrupt (g_interrupt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_adr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_re = 1'b1; reg_adr = a;
        tick();
        reg_re = 1'b0;
        d = reg_rdata;
    endtask

    task automatic do_reset();
        irq_in = '0; csr_meie = 1'b0; reg_we = 1'b0; reg_re = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", reg_rdata); end
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL reset_gint got %b exp 0", g_interrupt); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL enable_mask got %h exp 000000ff", d); end
        wr(2'd1, 32'h1234_56A5);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL mode_rw got %h exp 000000a5", d); end
    endtask

    task automatic test_edge_capture();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h04); wr(2'd1, 32'h04); csr_meie = 1'b1;
        irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0;  // edge 1
        tick();                                      // edge 2
        rd(2'd2, d);                                 // edge 3: samples pre-set value
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_early got %h exp 0", d); end
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL edge_gint_early got %b exp 0", g_interrupt); end
        rd(2'd2, d);                                 // edge 4
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL edge_pend got %h exp 4", d); end
        checks++; if (g_interrupt !== 1'b1) begin errors++; $display("FAIL edge_gint got %b exp 1", g_interrupt); end
        rd(2'd3, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL edge_claim got %0d exp 3", d); end
        checks++; if (g_interrupt !== 1'b1) begin errors++; $display("FAIL edge_gint_hold got %b exp 1", g_interrupt); end
        tick();
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL edge_gint_fall got %b exp 0", g_interrupt); end
        checks++; if (reg_rdata !== 32'd3) begin errors++; $display("FAIL rdata_hold got %0d exp 3", reg_rdata); end
        wr(2'd3, 32'd3); tick(); tick();
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL edge_after_cmp got %b exp 0", g_interrupt); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_clr got %h exp 0", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'hFF); wr(2'd1, 32'hFF); csr_meie = 1'b1;
        irq_in = 8'h22; tick(); irq_in = '0;
        repeat (4) tick();
        checks++; if (g_interrupt !== 1'b1) begin errors++; $display("FAIL prio_gint got %b exp 1", g_interrupt); end
        rd(2'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL prio_claim1 got %0d exp 2", d); end
        wr(2'd3, 32'd2);
        rd(2'd3, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL prio_claim2 got %0d exp 6", d); end
        wr(2'd3, 32'd6);
        rd(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_claim3 got %0d exp 0", d); end
    endtask

    task automatic test_level_repend();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h01); wr(2'd1, 32'h00); csr_meie = 1'b1;
        irq_in[0] = 1'b1;
        repeat (5) tick();
        rd(2'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL lvl_claim got %0d exp 1", d); end
        tick();
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL lvl_gint_svc got %b exp 0", g_interrupt); end
        wr(2'd3, 32'd1);
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL lvl_gint_cmp got %b exp 0", g_interrupt); end
        tick();
        checks++; if (g_interrupt !== 1'b1) begin errors++; $display("FAIL lvl_reassert got %b exp 1", g_interrupt); end
        irq_in[0] = 1'b0;
        repeat (3) tick();
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lvl_drop got %h exp 0", d); end
    endtask

    task automatic test_guarding();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h18); wr(2'd1, 32'h18); csr_meie = 1'b1;
        irq_in = 8'h18; tick(); irq_in = '0;
        repeat (4) tick();
        rd(2'd3, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL grd_claim got %0d exp 4", d); end
        rd(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL grd_claim2 got %0d exp 0", d); end
        wr(2'd3, 32'd5); tick();
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL grd_bad_cmp got %b exp 0", g_interrupt); end
        rd(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL grd_still_svc got %0d exp 0", d); end
        wr(2'd3, 32'd4); tick();
        checks++; if (g_interrupt !== 1'b1) begin errors++; $display("FAIL grd_cmp_gint got %b exp 1", g_interrupt); end
        csr_meie = 1'b0; tick();
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL grd_meie got %b exp 0", g_interrupt); end
        rd(2'd2, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL grd_pend got %h exp 10", d); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h01); wr(2'd1, 32'h01);
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        repeat (4) tick();
        rd(2'd2, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL sw_pend_init got %h exp 1", d); end
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;  // edge 1
        tick();                                      // edge 2: rise visible
        wr(2'd2, 32'h01);                            // W1C and set at edge 3
        rd(2'd2, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL sw_set_wins got %h exp 1", d); end
        wr(2'd2, 32'h01);
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_w1c got %h exp 0", d); end
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        do_reset();
        wr(2'd0, 32'h01); wr(2'd1, 32'h01); csr_meie = 1'b1;
        irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
        repeat (4) tick();
        rd(2'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL rst_claim got %0d exp 1", d); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (g_interrupt !== 1'b0) begin errors++; $display("FAIL rst_gint got %b exp 0", g_interrupt); end
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", reg_rdata); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_reg%0d got %h exp 0", a, d); end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_edge_capture();
        test_priority();
        test_level_repend();
        test_guarding();
        test_set_wins();
        test_reset_mid_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised multi-source machine-level interrupt controller for the RV32I core. It replaces the single-input `interrupter` path that turns `interrupt_0` and `csr_meie` into `g_interrupt`. It accepts `N_IRQ` asynchronous sources, each configurable as edge or level, latches them into pending bits and gates them with per-source enables. It raises `g_interrupt` toward the EX stage and exposes a claim/complete register window on the IO store/load path.

## Interface
- `N_IRQ`, default 8: number of interrupt sources, legal range 1..31.
- `SYNC_STAGES`, default 2: synchronizer flop depth per source, minimum 2.
- `ID_W`, default `$clog2(N_IRQ+1)`: width of a claim ID, where ID = source index + 1 and 0 = none.

Reset is synchronous and active-low; there is one clock.

- `clk` in 1: core clock.
- `rst_n` in 1: synchronous active-low reset.
- `irq_in` in `N_IRQ`: asynchronous interrupt sources, active high.
- `csr_meie` in 1: machine external interrupt enable, from the EX-stage CSR file.
- `reg_we` in 1: register write strobe.
- `reg_re` in 1: register read strobe.
- `reg_adr` in [3:2]: register select.
- `reg_wdata` in 32: write data.
- `reg_rdata` out 32: read data, registered.
- `g_interrupt` out 1: interrupt request to the pipeline, registered.

## Operation
- Registers, by `reg_adr`:
  - 0 ENABLE: RW, bit i enables source i.
  - 1 MODE: RW, bit i = 1 means edge, 0 means level.
  - 2 PENDING: read returns pending. Write-1-to-clear affects edge-mode bits only.
  - 3 CLAIM: a read claims; a write completes.
- Bits at or above `N_IRQ` read 0 and ignore writes.
- Synchronizer: each source passes through `SYNC_STAGES` flops. An edge-detect flop follows, and a rise is a `0->1` transition between the last sync flop and the detect flop.
- Pending set:
  - Edge mode: a rising edge sets pending[i].
  - Level mode: pending[i] follows the synced level every cycle.
- Pending clear: a claim of source i clears an edge-mode pending[i].
- In-service: the controller holds one register `insvc_id` (`ID_W` bits; 0 = idle). There is no nesting.
- Candidate: the lowest index i with `pending[i] & enable[i]`. Fixed priority, index 0 highest.
- `g_interrupt` next = `csr_meie & (insvc_id==0) & |(pending & enable)`.
- Claim (`reg_re` with adr 3):
  - If `insvc_id==0` and a candidate exists: rdata = candidate ID, `insvc_id` takes that ID, and edge pending is cleared.
  - Otherwise rdata = 0 and no state changes.
- Complete (`reg_we` with adr 3): if `reg_wdata[ID_W-1:0] == insvc_id` and `insvc_id != 0`, `insvc_id` returns to 0. Any other value is ignored.
- Simultaneous events:
  - A new edge in the same cycle as the claim or W1C of the same source leaves pending set; set wins.
  - `reg_we` and `reg_re` in the same cycle: the write is performed and the read returns the pre-write value.
  - A claim and a complete never coincide, because `reg_we` and `reg_re` to adr 3 together performs the complete only.
- A level source that is still high after complete re-pends immediately and re-raises `g_interrupt` one cycle later.
- Disabling a source does not clear its pending bit. Changing MODE from level to edge clears pending for that bit.

## Timing
- Reset values are all 0: sync flops, edge flops, ENABLE, MODE, pending, `insvc_id`, `reg_rdata`, `g_interrupt`.
- A reset asserted mid-service drops the in-service state; no complete is needed.
- `irq_in` rise to pending set: `SYNC_STAGES+1` cycles. Pending to `g_interrupt`: +1 cycle. The total for the default parameters is 4 cycles.
- `reg_rdata` is valid the cycle after `reg_re` and holds until the next read.
- Claim side effects (`insvc_id`, pending clear) take effect at the edge ending the `reg_re` cycle. `g_interrupt` drops on the following edge.
- Complete takes effect at the edge ending the `reg_we` cycle. `g_interrupt` may reassert one cycle later.
- `csr_meie` deassertion drops `g_interrupt` one cycle later; pending is unaffected.

## Structure
- Package `irq_ctrl_pkg`: register offsets (`IRQ_ENABLE=0`, `IRQ_MODE=1`, `IRQ_PENDING=2`, `IRQ_CLAIM=3`) and the `ID_NONE=0` constant.
- Sub-module `irq_sync`, one per source via generate: `SYNC_STAGES` synchronizer plus edge detector, with outputs `lvl` and `rise`.
- The top contains the registers, priority encoder, claim/complete logic and `g_interrupt` flop.

## Test plan
- **Edge capture.** ENABLE=`0x04`, MODE=`0x04`, `csr_meie`=1, pulse `irq_in[2]` for 1 cycle.
  - Pending bit 2 sets at +3 and `g_interrupt`=1 at +4.
  - A CLAIM read returns 3 and `g_interrupt` falls after 2 cycles.
  - Complete with 3 leaves it low.
- **Priority.** ENABLE=`0xFF`, edge mode, raise sources 5 and 1 in the same cycle.
  - Claim returns 2; complete.
  - Claim returns 6; complete.
  - Claim returns 0.
- **Level re-pend.** MODE=0, hold `irq_in[0]` high, claim (returns 1), complete with 1.
  - `g_interrupt` reasserts 1 cycle after the complete.
  - After dropping `irq_in[0]`, pending clears within `SYNC_STAGES+1` cycles.
- **Guarding.** With source 3 in service, a second claim returns 0.
  - Complete with 5 is ignored and `insvc_id` stays 4.
  - `csr_meie`=0 keeps `g_interrupt`=0 while PENDING reads nonzero.
- **Set-wins and W1C.** Write PENDING=`0x01` in the same cycle a new edge on source 0 lands.
  - Pending[0] stays 1.
  - A W1C write on the next cycle with no edge clears it.
- **Reset mid-service.** Claim source 0, then assert `rst_n`=0 for 1 cycle.
  - All registers read 0, `g_interrupt`=0, and the next claim returns 0.
